// File: rtl/priv_1_12_trap_sequencer_if.sv
// Bus bundle between the trap sequencer, the pipeline hazard unit and the CSR block.
// The sequencer connects through the slave modport; the pipeline/CSR side uses master.
interface priv_1_12_trap_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            exc_valid;
  logic [3:0]      exc_cause;
  logic [XLEN-1:0] exc_epc;
  logic [XLEN-1:0] exc_tval;
  logic [2:0]      int_req;
  logic            mstatus_mie;
  logic            mret;
  logic [XLEN-1:0] int_epc;
  logic            pipe_drained;
  logic            redirect_ack;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic            pipe_flush;
  logic            trap_commit;
  logic            mret_commit;
  logic [XLEN-1:0] commit_mcause;
  logic [XLEN-1:0] commit_mepc;
  logic [XLEN-1:0] commit_mtval;
  logic            insert_pc;
  logic [XLEN-1:0] priv_pc;
  logic            busy;
  logic            drain_timeout;

  modport slave (
    input  exc_valid, exc_cause, exc_epc, exc_tval, int_req, mstatus_mie, mret,
           int_epc, pipe_drained, redirect_ack, mtvec, mepc,
    output pipe_flush, trap_commit, mret_commit, commit_mcause, commit_mepc,
           commit_mtval, insert_pc, priv_pc, busy, drain_timeout
  );

  modport master (
    output exc_valid, exc_cause, exc_epc, exc_tval, int_req, mstatus_mie, mret,
           int_epc, pipe_drained, redirect_ack, mtvec, mepc,
    input  pipe_flush, trap_commit, mret_commit, commit_mcause, commit_mepc,
           commit_mtval, insert_pc, priv_pc, busy, drain_timeout
  );
endinterface

// File: rtl/priv_1_12_trap_sequencer.sv
// Machine-mode trap entry / mret sequencer: arbitrates one exception and three
// M-mode interrupts, drains the pipeline, strobes a one-cycle CSR commit and then
// holds the PC redirect until the pipeline accepts it.
module priv_1_12_trap_sequencer #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned DRAIN_TIMEOUT = 15
) (
  input logic                       CLK,
  input logic                       nRST,
  priv_1_12_trap_sequencer_if.slave bus
);
  localparam int unsigned CW = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;
  typedef enum logic [1:0] {K_EXC, K_INT, K_MRET} kind_t;

  state_t          r_state, w_next;
  kind_t           r_kind, w_kind;
  logic [3:0]      r_cause, w_cause;
  logic [XLEN-1:0] r_epc, r_tval, r_target;
  logic [XLEN-1:0] w_epc, w_tval;
  logic [CW-1:0]   r_cnt;
  logic            w_pending;
  logic            w_timeout;
  logic [XLEN-1:0] w_vec_base, w_trap_target;

  logic            w_trap_commit, w_mret_commit, w_insert_pc, w_drain_timeout;
  logic [XLEN-1:0] w_mcause, w_mepc, w_mtval, w_priv_pc;

  // Fixed-priority arbitration of the pending sources: exception > interrupt > mret
  always_comb begin
    w_pending = 1'b1;
    w_kind    = K_EXC;
    w_cause   = '0;
    w_epc     = '0;
    w_tval    = '0;
    if (bus.exc_valid) begin
      w_cause = bus.exc_cause;
      w_epc   = bus.exc_epc;
      w_tval  = bus.exc_tval;
    end else if (bus.mstatus_mie && (bus.int_req != 3'b000)) begin
      w_kind = K_INT;
      w_epc  = bus.int_epc;
      if (bus.int_req[2])      w_cause = 4'd11;
      else if (bus.int_req[1]) w_cause = 4'd3;
      else                     w_cause = 4'd7;
    end else if (bus.mret) begin
      w_kind = K_MRET;
    end else begin
      w_pending = 1'b0;
    end
  end

  // Trap target from mtvec: vectored only for interrupts in mode 01, otherwise direct
  always_comb begin
    w_vec_base    = {bus.mtvec[XLEN-1:2], 2'b00};
    w_trap_target = w_vec_base;
    if ((r_kind == K_INT) && (bus.mtvec[1:0] == 2'b01))
      w_trap_target = w_vec_base + (XLEN'(r_cause) << 2);
  end

  // Drain exits via timeout only when the pipeline has not reported drained itself
  always_comb begin
    w_timeout = (r_state == DRAIN) && !bus.pipe_drained && (r_cnt == CW'(DRAIN_TIMEOUT));
  end

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state and per-state output strobes
  always_comb begin
    w_next          = r_state;
    w_trap_commit   = 1'b0;
    w_mret_commit   = 1'b0;
    w_insert_pc     = 1'b0;
    w_drain_timeout = 1'b0;
    w_mcause        = '0;
    w_mepc          = '0;
    w_mtval         = '0;
    w_priv_pc       = '0;
    case (r_state)
      IDLE: begin
        if (w_pending) w_next = DRAIN;
      end
      DRAIN: begin
        w_drain_timeout = w_timeout;
        if (bus.pipe_drained || w_timeout) w_next = COMMIT;
      end
      COMMIT: begin
        w_next = REDIRECT;
        if (r_kind == K_MRET) begin
          w_mret_commit = 1'b1;
        end else begin
          w_trap_commit      = 1'b1;
          w_mcause[3:0]      = r_cause;
          w_mcause[XLEN-1]   = (r_kind == K_INT);
          w_mepc             = r_epc;
          w_mtval            = r_tval;
        end
      end
      REDIRECT: begin
        w_insert_pc = 1'b1;
        w_priv_pc   = r_target;
        if (bus.redirect_ack) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Latched trap context, drain counter and redirect target
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_kind   <= K_EXC;
      r_cause  <= '0;
      r_epc    <= '0;
      r_tval   <= '0;
      r_target <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pending) begin
            r_kind   <= w_kind;
            r_cause  <= w_cause;
            r_epc    <= w_epc;
            r_tval   <= w_tval;
            r_target <= (w_kind == K_MRET) ? bus.mepc : '0;
            r_cnt    <= '0;
          end
        end
        DRAIN: begin
          if (w_next == DRAIN) r_cnt <= r_cnt + 1'b1;
        end
        COMMIT: begin
          if (r_kind != K_MRET) r_target <= w_trap_target;
        end
        default: ;
      endcase
    end
  end

  assign bus.pipe_flush    = (r_state != IDLE);
  assign bus.busy          = (r_state != IDLE);
  assign bus.trap_commit   = w_trap_commit;
  assign bus.mret_commit   = w_mret_commit;
  assign bus.commit_mcause = w_mcause;
  assign bus.commit_mepc   = w_mepc;
  assign bus.commit_mtval  = w_mtval;
  assign bus.insert_pc     = w_insert_pc;
  assign bus.priv_pc       = w_priv_pc;
  assign bus.drain_timeout = w_drain_timeout;
endmodule

// File: tb/tb_priv_1_12_trap_sequencer.sv
// Scoreboard bench for the trap sequencer: the driver pushes expected commits
// computed from the architectural trap rules; a monitor pops and compares them.
module tb_priv_1_12_trap_sequencer;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_mret;
    logic [31:0] mcause, mepc, mtval, target;
    int unsigned issue, dly, ackd;
    bit          timeout;
  } exp_t;

  exp_t q[$];

  priv_1_12_trap_sequencer_if #(.XLEN(32)) bus ();

  priv_1_12_trap_sequencer #(.XLEN(32), .DRAIN_TIMEOUT(15)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %h expected no event", nm, act);
  endtask

  // Architectural view of what one arbitration in IDLE should produce
  function automatic bit model(input bit e, input logic [3:0] c, input logic [31:0] eepc,
                               input logic [31:0] etval, input logic [2:0] ir, input bit mie,
                               input bit mr, input logic [31:0] iepc, input logic [31:0] mtv,
                               input logic [31:0] mep, output exp_t x);
    logic [31:0] base;
    int unsigned code;
    base = mtv & 32'hFFFF_FFFC;
    x.is_mret = 0; x.mcause = 0; x.mepc = 0; x.mtval = 0; x.target = 0;
    x.issue = 0; x.dly = 0; x.ackd = 0; x.timeout = 0;
    if (e) begin
      x.mcause = {28'd0, c};
      x.mepc   = eepc;
      x.mtval  = etval;
      x.target = base;
      return 1;
    end
    if (mie && ir != 3'b000) begin
      code     = ir[2] ? 11 : (ir[1] ? 3 : 7);
      x.mcause = 32'h8000_0000 + code;
      x.mepc   = iepc;
      x.mtval  = 0;
      x.target = (mtv[1:0] == 2'b01) ? base + code * 4 : base;
      return 1;
    end
    if (mr) begin
      x.is_mret = 1;
      x.target  = mep;
      return 1;
    end
    return 0;
  endfunction

  task automatic clear_reqs();
    bus.exc_valid = 0;
    bus.mret      = 0;
    bus.int_req   = 3'b000;
  endtask

  // One request: drive, predict, then play pipeline (drain after dly cycles, ack after ackd)
  task automatic run_txn(input bit e, input logic [3:0] c, input logic [31:0] eepc,
                         input logic [31:0] etval, input logic [2:0] ir, input bit mie,
                         input bit mr, input logic [31:0] iepc, input logic [31:0] mtv,
                         input logic [31:0] mep, input int unsigned dly, input int unsigned ackd);
    exp_t x;
    bit pend, seen_ins, done;
    int unsigned w;
    @(negedge CLK);
    bus.exc_valid = e; bus.exc_cause = c; bus.exc_epc = eepc; bus.exc_tval = etval;
    bus.int_req = ir; bus.mstatus_mie = mie; bus.mret = mr; bus.int_epc = iepc;
    bus.mtvec = mtv; bus.mepc = mep; bus.pipe_drained = 0; bus.redirect_ack = 0;
    pend = model(e, c, eepc, etval, ir, mie, mr, iepc, mtv, mep, x);
    x.issue = cyc; x.dly = dly; x.ackd = ackd; x.timeout = (dly >= 16);
    if (!pend) begin
      repeat (4) begin
        @(negedge CLK);
        chk("idle_hold_busy", {31'd0, bus.busy}, 32'd0);
      end
      clear_reqs();
      return;
    end
    q.push_back(x);
    seen_ins = 0; done = 0; w = 0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge CLK);
      if (n == 0) begin
        chk("flush_after_req", {31'd0, bus.pipe_flush}, 32'd1);
        clear_reqs();
      end
      if (bus.insert_pc) begin
        seen_ins = 1;
        bus.redirect_ack = (w == ackd);
        w++;
      end else if (seen_ins) begin
        bus.redirect_ack = 0;
        done = !bus.busy;
      end else begin
        bus.pipe_drained = (n >= dly);
        bus.redirect_ack = ($urandom_range(0, 1) == 1);
      end
    end
    if (!done) flag("txn_no_return_to_idle", {31'd0, bus.busy});
    bus.pipe_drained = 0;
    bus.redirect_ack = 0;
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_flags"}, {26'd0, bus.pipe_flush, bus.trap_commit, bus.mret_commit,
                         bus.insert_pc, bus.busy, bus.drain_timeout}, 32'd0);
    chk({nm, "_data"}, bus.commit_mcause | bus.commit_mepc | bus.commit_mtval | bus.priv_pc, 32'd0);
  endtask

  // Monitor: pops expectations when the DUT strobes a commit, tracks the redirect window
  initial begin : monitor
    exp_t cur;
    bit have_cur;
    int unsigned commit_cyc, ins_cnt;
    int last_to;
    have_cur = 0; ins_cnt = 0; last_to = -10; commit_cyc = 0;
    cur.is_mret = 0; cur.mcause = 0; cur.mepc = 0; cur.mtval = 0; cur.target = 0;
    cur.issue = 0; cur.dly = 0; cur.ackd = 0; cur.timeout = 0;
    forever begin
      @(negedge CLK);
      if (nRST) begin
        if (bus.drain_timeout) last_to = int'(cyc);
        if (bus.trap_commit && bus.mret_commit) flag("both_strobes", 32'd1);
        if (bus.trap_commit || bus.mret_commit) begin
          if (q.size() == 0) begin
            flag("unexpected_commit", {30'd0, bus.trap_commit, bus.mret_commit});
          end else begin
            cur = q.pop_front();
            have_cur = 1;
            commit_cyc = cyc;
            chk("commit_kind", {31'd0, bus.mret_commit}, {31'd0, cur.is_mret});
            if (!cur.is_mret) begin
              chk("mcause", bus.commit_mcause, cur.mcause);
              chk("mepc", bus.commit_mepc, cur.mepc);
              chk("mtval", bus.commit_mtval, cur.mtval);
            end
            chk("commit_latency", cyc - cur.issue, cur.timeout ? 32'd17 : cur.dly + 2);
            chk("drain_timeout_pulse", {31'd0, last_to == int'(cyc) - 1}, {31'd0, cur.timeout});
          end
        end
        if (bus.insert_pc) begin
          if (!have_cur) begin
            flag("unexpected_insert_pc", bus.priv_pc);
          end else begin
            if (ins_cnt == 0) chk("insert_latency", cyc - commit_cyc, 32'd1);
            chk("priv_pc", bus.priv_pc, cur.target);
            ins_cnt++;
          end
        end else if (ins_cnt != 0) begin
          chk("redirect_hold_cycles", ins_cnt, cur.ackd + 1);
          ins_cnt = 0;
          have_cur = 0;
        end
      end else begin
        have_cur = 0;
        ins_cnt = 0;
      end
    end
  end

  initial begin : driver
    bus.exc_valid = 0; bus.exc_cause = 0; bus.exc_epc = 0; bus.exc_tval = 0;
    bus.int_req = 0; bus.mstatus_mie = 0; bus.mret = 0; bus.int_epc = 0;
    bus.pipe_drained = 0; bus.redirect_ack = 0; bus.mtvec = 0; bus.mepc = 0;
    repeat (2) @(negedge CLK);
    chk_outputs_zero("reset");
    nRST = 1;

    // Exception uses direct mode even with vectored mtvec; ack held off 5 cycles
    run_txn(1, 4'd2, 32'h100, 32'hDEAD, 3'b000, 0, 0, 32'h0, 32'h8001, 32'h0, 0, 5);
    // All interrupts: ext wins, vectored target
    run_txn(0, 4'd0, 32'h0, 32'h0, 3'b111, 1, 0, 32'h200, 32'h8001, 32'h0, 0, 0);
    // Timer interrupt masked globally: nothing happens; then enabled
    run_txn(0, 4'd0, 32'h0, 32'h0, 3'b001, 0, 0, 32'h300, 32'h8001, 32'h0, 0, 0);
    run_txn(0, 4'd0, 32'h0, 32'h0, 3'b001, 1, 0, 32'h300, 32'h8001, 32'h0, 1, 1);
    // Exception and mret together: trap only; then mret alone
    run_txn(1, 4'd11, 32'h400, 32'h0, 3'b000, 0, 1, 32'h0, 32'h9000, 32'h1234, 2, 0);
    run_txn(0, 4'd0, 32'h0, 32'h0, 3'b000, 0, 1, 32'h0, 32'h9000, 32'h1234, 0, 2);
    // Pipeline never drains: forced commit after timeout
    run_txn(1, 4'd5, 32'h500, 32'h55, 3'b000, 0, 0, 32'h0, 32'h8000, 32'h0, 40, 1);
    // Vectored base near the top of the address space wraps
    run_txn(0, 4'd0, 32'h0, 32'h0, 3'b100, 1, 0, 32'h600, 32'hFFFF_FFF1, 32'h0, 0, 0);

    // Reset in the middle of DRAIN: outputs return to zero, no strobe afterwards
    @(negedge CLK);
    bus.exc_valid = 1; bus.exc_cause = 4'd7; bus.exc_epc = 32'h700; bus.pipe_drained = 0;
    repeat (3) @(negedge CLK);
    chk("pre_reset_busy", {31'd0, bus.busy}, 32'd1);
    clear_reqs();
    nRST = 0;
    #1;
    chk_outputs_zero("mid_drain_reset");
    repeat (2) @(negedge CLK);
    nRST = 1;
    repeat (6) begin
      @(negedge CLK);
      chk("post_reset_idle", {31'd0, bus.busy}, 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      int unsigned dly;
      dly = ($urandom_range(0, 7) == 0) ? 40 : $urandom_range(0, 4);
      run_txn($urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)), $urandom, $urandom,
              3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              $urandom, $urandom, $urandom, dly, $urandom_range(0, 3));
    end

    repeat (3) @(negedge CLK);
    chk("scoreboard_empty", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
